// File: rtl/bus_latch_buffer.sv
// rtl/bus_latch_buffer.sv - latched bus buffer: LE-strobed FIFO capture, OE_n-gated output, optional parity (BUS_LATCH_BUFFER_PARITY_EN)
module bus_latch_buffer #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             sysclk,
    input  logic             sys_rst,
    input  logic [WIDTH-1:0] D,
    input  logic             LE,
    input  logic             RD,
    input  logic             OE_n,
    input  logic             CLR_OVF,
    output logic [WIDTH-1:0] Y,
    output logic             EMPTY,
    output logic             FULL,
    output logic [CW-1:0]    COUNT,
    output logic             OVF
`ifdef BUS_LATCH_BUFFER_PARITY_EN
    ,
    output logic             PAR
`endif
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [WIDTH-1:0] hold;
    logic             push;
    logic             pop;
    logic             ovf_set;
    logic [CW-1:0]    count_next;

`ifdef BUS_LATCH_BUFFER_PARITY_EN
    logic             par_mem [DEPTH];
    logic             hold_par;
`endif

    // Push/pop qualification; a pop on full frees the slot the push reuses
    always_comb begin
        push       = LE && (!FULL || RD);
        pop        = RD && !EMPTY;
        ovf_set    = LE && FULL && !RD;
        count_next = COUNT;
        if (push && !pop) begin
            count_next = COUNT + CW'(1);
        end else if (pop && !push) begin
            count_next = COUNT - CW'(1);
        end
    end

    // Pointers, occupancy, registered flags, sticky overflow and hold word
    always_ff @(posedge sysclk) begin
        if (sys_rst) begin
            wptr  <= '0;
            rptr  <= '0;
            COUNT <= '0;
            EMPTY <= 1'b1;
            FULL  <= 1'b0;
            OVF   <= 1'b0;
            hold  <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + AW'(1);
            end
            if (pop) begin
                rptr <= rptr + AW'(1);
                hold <= mem[rptr];
            end
            COUNT <= count_next;
            EMPTY <= (count_next == '0);
            FULL  <= (count_next == CW'(DEPTH));
            if (ovf_set) begin
                OVF <= 1'b1;
            end else if (CLR_OVF) begin
                OVF <= 1'b0;
            end
        end
    end

    // Storage array; contents need no reset since pointers gate visibility
    always_ff @(posedge sysclk) begin
        if (!sys_rst && push) begin
            mem[wptr] <= D;
        end
    end

    // Output mux: head word when stored, else last popped word, zero when disabled
    always_comb begin
        Y = '0;
        if (!OE_n) begin
            Y = EMPTY ? hold : mem[rptr];
        end
    end

`ifdef BUS_LATCH_BUFFER_PARITY_EN
    // Odd-parity bit follows each word through the array and the hold register
    always_ff @(posedge sysclk) begin
        if (sys_rst) begin
            hold_par <= 1'b1;
        end else begin
            if (push) begin
                par_mem[wptr] <= ~^D;
            end
            if (pop) begin
                hold_par <= par_mem[rptr];
            end
        end
    end

    // Parity of the word currently selected for Y
    always_comb begin
        PAR = 1'b0;
        if (!OE_n) begin
            PAR = EMPTY ? hold_par : par_mem[rptr];
        end
    end
`endif

endmodule

// File: tb/tb_bus_latch_buffer.sv
// tb/tb_bus_latch_buffer.sv - scoreboard bench for bus_latch_buffer (DEPTH=4, WIDTH=10)
module tb_bus_latch_buffer;

    logic       sysclk = 1'b0;
    logic       sys_rst = 1'b0;
    logic [9:0] D = '0;
    logic       LE = 1'b0;
    logic       RD = 1'b0;
    logic       OE_n = 1'b0;
    logic       CLR_OVF = 1'b0;
    logic [9:0] Y;
    logic       EMPTY;
    logic       FULL;
    logic [2:0] COUNT;
    logic       OVF;
`ifdef BUS_LATCH_BUFFER_PARITY_EN
    logic       PAR;
`endif

    int total = 0;
    int bad = 0;

    logic [9:0] sb[$];
    logic [9:0] hold_m;
    logic       ovf_m;

    bus_latch_buffer dut (
        .sysclk  (sysclk),
        .sys_rst (sys_rst),
        .D       (D),
        .LE      (LE),
        .RD      (RD),
        .OE_n    (OE_n),
        .CLR_OVF (CLR_OVF),
        .Y       (Y),
        .EMPTY   (EMPTY),
        .FULL    (FULL),
        .COUNT   (COUNT),
        .OVF     (OVF)
`ifdef BUS_LATCH_BUFFER_PARITY_EN
        ,
        .PAR     (PAR)
`endif
    );

    always #5 sysclk = ~sysclk;

    task automatic do_reset();
        sys_rst = 1'b1;
        LE = 1'b0;
        RD = 1'b0;
        CLR_OVF = 1'b0;
        @(posedge sysclk);
        #1;
        sys_rst = 1'b0;
        sb.delete();
        hold_m = '0;
        ovf_m = 1'b0;
    endtask

    // One clock of stimulus; the reference queue follows the documented push/pop rules
    task automatic step(input logic le, input logic [9:0] d, input logic rd, input logic clr);
        bit full_m, empty_m, do_push, do_pop;
        LE = le;
        D = d;
        RD = rd;
        CLR_OVF = clr;
        full_m  = (sb.size() == 4);
        empty_m = (sb.size() == 0);
        do_push = le && (!full_m || rd);
        do_pop  = rd && !empty_m;
        if (le && full_m && !rd) ovf_m = 1'b1;
        else if (clr) ovf_m = 1'b0;
        if (do_pop) hold_m = sb.pop_front();
        if (do_push) sb.push_back(d);
        @(posedge sysclk);
        #1;
        LE = 1'b0;
        RD = 1'b0;
        CLR_OVF = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        OE_n = 1'b0;
        #1;
        total++; if (Y !== 10'h000) begin bad++; $display("FAIL reset_y got=%h exp=%h", Y, 10'h000); end
        total++; if (EMPTY !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b exp=1", EMPTY); end
        total++; if (FULL !== 1'b0) begin bad++; $display("FAIL reset_full got=%b exp=0", FULL); end
        total++; if (COUNT !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", COUNT); end
        total++; if (OVF !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", OVF); end
        step(1'b1, 10'h111, 1'b0, 1'b0);
        step(1'b1, 10'h222, 1'b0, 1'b0);
        total++; if (COUNT !== 3'd2) begin bad++; $display("FAIL pre_rst_count got=%0d exp=2", COUNT); end
        do_reset();
        total++; if (COUNT !== 3'd0) begin bad++; $display("FAIL midrst_count got=%0d exp=0", COUNT); end
        total++; if (Y !== 10'h000) begin bad++; $display("FAIL midrst_y got=%h exp=000", Y); end
        total++; if (EMPTY !== 1'b1) begin bad++; $display("FAIL midrst_empty got=%b exp=1", EMPTY); end
    endtask

    task automatic test_fill_drain();
        logic [9:0] pats [4];
        logic [9:0] e;
        pats = '{10'h155, 10'h2AA, 10'h001, 10'h3FF};
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, pats[i], 1'b0, 1'b0);
        total++; if (FULL !== 1'b1) begin bad++; $display("FAIL fill_full got=%b exp=1", FULL); end
        total++; if (COUNT !== 3'd4) begin bad++; $display("FAIL fill_count got=%0d exp=4", COUNT); end
        total++; if (Y !== 10'h155) begin bad++; $display("FAIL fill_head got=%h exp=155", Y); end
        for (int i = 0; i < 4; i++) begin
            e = sb[0];
            total++; if (Y !== e) begin bad++; $display("FAIL drain_y%0d got=%h exp=%h", i, Y, e); end
            step(1'b0, 10'h000, 1'b1, 1'b0);
        end
        total++; if (EMPTY !== 1'b1) begin bad++; $display("FAIL drain_empty got=%b exp=1", EMPTY); end
        total++; if (Y !== 10'h3FF) begin bad++; $display("FAIL drain_hold got=%h exp=3ff", Y); end
        step(1'b0, 10'h000, 1'b1, 1'b0);
        total++; if (Y !== 10'h3FF || COUNT !== 3'd0) begin bad++; $display("FAIL rd_on_empty got=%h/%0d exp=3ff/0", Y, COUNT); end
    endtask

    task automatic test_overflow();
        logic [9:0] e;
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 10'(i + 5), 1'b0, 1'b0);
        step(1'b1, 10'h0F0, 1'b0, 1'b0);
        total++; if (COUNT !== 3'd4) begin bad++; $display("FAIL ovf_count got=%0d exp=4", COUNT); end
        total++; if (OVF !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b exp=1", OVF); end
        step(1'b0, 10'h000, 1'b0, 1'b0);
        total++; if (OVF !== ovf_m) begin bad++; $display("FAIL ovf_sticky got=%b exp=%b", OVF, ovf_m); end
        step(1'b1, 10'h0F1, 1'b0, 1'b1);
        total++; if (OVF !== 1'b1) begin bad++; $display("FAIL ovf_setwins got=%b exp=1", OVF); end
        step(1'b0, 10'h000, 1'b0, 1'b1);
        total++; if (OVF !== 1'b0) begin bad++; $display("FAIL ovf_clr got=%b exp=0", OVF); end
        for (int i = 0; i < 4; i++) begin
            e = sb[0];
            total++; if (Y !== e || Y === 10'h0F0) begin bad++; $display("FAIL ovf_drain%0d got=%h exp=%h", i, Y, e); end
            step(1'b0, 10'h000, 1'b1, 1'b0);
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] e;
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 10'(i + 1), 1'b0, 1'b0);
        step(1'b1, 10'h123, 1'b1, 1'b0);
        total++; if (COUNT !== 3'd4 || OVF !== 1'b0) begin bad++; $display("FAIL full_lerd got=%0d/%b exp=4/0", COUNT, OVF); end
        for (int i = 0; i < 4; i++) begin
            e = sb[0];
            total++; if (Y !== e) begin bad++; $display("FAIL full_lerd_pop%0d got=%h exp=%h", i, Y, e); end
            if (i == 3) begin
                total++; if (Y !== 10'h123) begin bad++; $display("FAIL full_lerd_4th got=%h exp=123", Y); end
            end
            step(1'b0, 10'h000, 1'b1, 1'b0);
        end
        do_reset();
        step(1'b1, 10'h050, 1'b1, 1'b0);
        total++; if (COUNT !== 3'd1) begin bad++; $display("FAIL empty_lerd_count got=%0d exp=1", COUNT); end
        total++; if (Y !== 10'h050) begin bad++; $display("FAIL empty_lerd_y got=%h exp=050", Y); end
        step(1'b0, 10'h000, 1'b1, 1'b0);
        total++; if (Y !== hold_m || EMPTY !== 1'b1) begin bad++; $display("FAIL empty_lerd_hold got=%h exp=%h", Y, hold_m); end
    endtask

    task automatic test_oe();
        do_reset();
        step(1'b1, 10'h2AA, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            OE_n = 1'b1;
            #1;
            total++; if (Y !== 10'h000) begin bad++; $display("FAIL oe_off%0d got=%h exp=000", i, Y); end
            OE_n = 1'b0;
            #1;
            total++; if (Y !== 10'h2AA) begin bad++; $display("FAIL oe_on%0d got=%h exp=2aa", i, Y); end
        end
        total++; if (COUNT !== 3'd1) begin bad++; $display("FAIL oe_count got=%0d exp=1", COUNT); end
    endtask

    task automatic test_wrap();
        logic [9:0] e;
        do_reset();
        step(1'b1, 10'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) begin
            e = sb[0];
            total++; if (Y !== e) begin bad++; $display("FAIL wrap_y%0d got=%h exp=%h", i, Y, e); end
            step(1'b1, 10'($urandom), 1'b1, 1'b0);
        end
        total++; if (COUNT !== 3'd1) begin bad++; $display("FAIL wrap_count got=%0d exp=1", COUNT); end
        e = sb[0];
        total++; if (Y !== e) begin bad++; $display("FAIL wrap_last got=%h exp=%h", Y, e); end
        for (int i = 0; i < 3; i++) step(1'b1, 10'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            e = sb[0];
            total++; if (Y !== e) begin bad++; $display("FAIL wrap_drain%0d got=%h exp=%h", i, Y, e); end
            step(1'b0, 10'h000, 1'b1, 1'b0);
        end
    endtask

`ifdef BUS_LATCH_BUFFER_PARITY_EN
    task automatic test_parity();
        do_reset();
        #1;
        total++; if (PAR !== 1'b1) begin bad++; $display("FAIL par_reset got=%b exp=1", PAR); end
        step(1'b1, 10'h001, 1'b0, 1'b0);
        total++; if (PAR !== 1'b0) begin bad++; $display("FAIL par_001 got=%b exp=0", PAR); end
        step(1'b1, 10'h003, 1'b1, 1'b0);
        total++; if (PAR !== 1'b1) begin bad++; $display("FAIL par_003 got=%b exp=1", PAR); end
        OE_n = 1'b1;
        #1;
        total++; if (PAR !== 1'b0) begin bad++; $display("FAIL par_oe got=%b exp=0", PAR); end
        OE_n = 1'b0;
    endtask
`endif

    initial begin
        hold_m = '0;
        ovf_m = 1'b0;
        test_reset();
        test_fill_drain();
        test_overflow();
        test_back_to_back();
        test_oe();
        test_wrap();
`ifdef BUS_LATCH_BUFFER_PARITY_EN
        test_parity();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
